// File: rtl/sys_timer_pkg.sv
// sys_timer_pkg: register map and field positions
// shared by the sys bus timer peripheral.
package sys_timer_pkg;

  localparam logic [2:0] OFS_CTRL    = 3'd0;
  localparam logic [2:0] OFS_COUNT   = 3'd1;
  localparam logic [2:0] OFS_COMPARE = 3'd2;
  localparam logic [2:0] OFS_STATUS  = 3'd3;
  localparam logic [2:0] OFS_CAPTURE = 3'd4;

  localparam int CTRL_EN = 0;
  localparam int CTRL_AR = 1;
  localparam int CTRL_IE = 2;
  localparam int PRE_LSB = 8;
  localparam int PRE_MSB = 15;

  localparam int ST_MATCH = 0;
  localparam int ST_OVF   = 1;
  localparam int ST_CAP   = 2;

  localparam logic [31:0] CTRL_MASK = 32'h0000_FF07;

  function automatic logic win_hit(
    input logic [26:0] a,
    input logic [26:0] base
  );
    return a == base;
  endfunction

endpackage

// File: rtl/sys_prescaler.sv
// sys_prescaler: 8-bit clock divider, one tick
// every PRESCALE+1 enabled cycles.
module sys_prescaler (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  input  logic [7:0] prescale,
  output logic       tick
);

  logic [7:0] pre_cnt;

  assign tick = en && (pre_cnt == prescale);

  // divider count, held at 0 while disabled
  always_ff @(posedge clk) begin
    if (!rst || clr || !en)
      pre_cnt <= '0;
    else if (tick)
      pre_cnt <= '0;
    else
      pre_cnt <= pre_cnt + 8'd1;
  end

endmodule

// File: rtl/sys_timer_periph.sv
// sys_timer_periph: memory-mapped 32-bit timer on the sys bus.
// Optional capture input enabled by SYS_TIMER_CAPTURE_EN.
module sys_timer_periph
  import sys_timer_pkg::*;
#(
  parameter logic [31:0] BASE          = 32'h0000_1000,
  parameter logic [31:0] RESET_COMPARE = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] sys_w_addr,
  input  logic [31:0] sys_w_line,
  input  logic        sys_write,
  input  logic [31:0] sys_r_addr,
  input  logic        sys_read,
  output logic [31:0] sys_r_line,
  output logic        sys_r_hit,
  input  logic        cap_in,
  output logic        irq
);

  logic [31:0] ctrl;
  logic [31:0] count;
  logic [31:0] count_nxt;
  logic [31:0] compare;
  logic [31:0] capture;
  logic [31:0] r_data;
  logic [2:0]  status;
  logic [2:0]  st_set;
  logic [2:0]  st_clr;
  logic [2:0]  w_ofs;
  logic [2:0]  r_ofs;
  logic        w_hit;
  logic        r_hit;
  logic        wr;
  logic        wr_ctrl;
  logic        wr_count;
  logic        wr_cmp;
  logic        wr_st;
  logic        tick;
  logic        tick_eff;
  logic        cap_rise;
  logic        unused_ok;

  assign w_hit = win_hit(sys_w_addr[31:5], BASE[31:5]);
  assign r_hit = win_hit(sys_r_addr[31:5], BASE[31:5]);
  assign w_ofs = sys_w_addr[4:2];
  assign r_ofs = sys_r_addr[4:2];

  assign wr       = sys_write && w_hit;
  assign wr_ctrl  = wr && (w_ofs == OFS_CTRL);
  assign wr_count = wr && (w_ofs == OFS_COUNT);
  assign wr_cmp   = wr && (w_ofs == OFS_COMPARE);
  assign wr_st    = wr && (w_ofs == OFS_STATUS);

  // a software COUNT write swallows a coincident tick
  assign tick_eff = tick && !wr_count;

  sys_prescaler u_pre (
    .clk      (clk),
    .rst      (rst),
    .en       (ctrl[CTRL_EN]),
    .clr      (wr_ctrl),
    .prescale (ctrl[PRE_MSB:PRE_LSB]),
    .tick     (tick)
  );

`ifdef SYS_TIMER_CAPTURE_EN
  logic [2:0] cap_sync;

  // two-flop synchronizer plus one stage for edge detect
  always_ff @(posedge clk) begin
    if (!rst)
      cap_sync <= '0;
    else
      cap_sync <= {cap_sync[1:0], cap_in};
  end

  assign cap_rise = cap_sync[1] & ~cap_sync[2];

  // snapshot COUNT before any same-cycle update
  always_ff @(posedge clk) begin
    if (!rst)
      capture <= '0;
    else if (cap_rise)
      capture <= count;
  end

  assign unused_ok = ^{sys_w_addr[1:0], sys_r_addr[1:0]};
`else
  assign cap_rise  = 1'b0;
  assign capture   = '0;
  assign unused_ok = ^{sys_w_addr[1:0], sys_r_addr[1:0], cap_in};
`endif

  // next COUNT and hardware status sets
  always_comb begin
    count_nxt = count;
    st_set    = '0;
    st_set[ST_CAP] = cap_rise;
    if (tick_eff) begin
      if (count == compare)
        st_set[ST_MATCH] = 1'b1;
      if (count == compare && ctrl[CTRL_AR]) begin
        count_nxt = '0;
      end else begin
        count_nxt = count + 32'd1;
        if (&count)
          st_set[ST_OVF] = 1'b1;
      end
    end
    if (wr_count)
      count_nxt = sys_w_line;
  end

  assign st_clr = wr_st ? sys_w_line[2:0] : 3'b000;

  // register file and interrupt
  always_ff @(posedge clk) begin
    if (!rst) begin
      ctrl    <= '0;
      count   <= '0;
      compare <= RESET_COMPARE;
      status  <= '0;
      irq     <= 1'b0;
    end else begin
      if (wr_ctrl)
        ctrl <= sys_w_line & CTRL_MASK;
      if (wr_cmp)
        compare <= sys_w_line;
      count  <= count_nxt;
      status <= (status & ~st_clr) | st_set;
      irq    <= ctrl[CTRL_IE] & (|status);
    end
  end

  // read mux over pre-write register values
  always_comb begin
    r_data = '0;
    unique case (1'b1)
      r_ofs == OFS_CTRL:    r_data = ctrl;
      r_ofs == OFS_COUNT:   r_data = count;
      r_ofs == OFS_COMPARE: r_data = compare;
      r_ofs == OFS_STATUS:  r_data = {29'd0, status};
      r_ofs == OFS_CAPTURE: r_data = capture;
      default:              r_data = '0;
    endcase
  end

  // registered read response
  always_ff @(posedge clk) begin
    if (!rst) begin
      sys_r_line <= '0;
      sys_r_hit  <= 1'b0;
    end else if (sys_read && r_hit) begin
      sys_r_line <= r_data;
      sys_r_hit  <= 1'b1;
    end else begin
      sys_r_line <= '0;
      sys_r_hit  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sys_timer_periph.sv
// tb_sys_timer_periph: directed bench for the sys
// bus timer; inputs driven and outputs sampled on negedge.
module tb_sys_timer_periph;

  localparam logic [31:0] B = 32'h0000_1000;
  localparam logic [2:0] O_CTRL = 3'd0;
  localparam logic [2:0] O_CNT  = 3'd1;
  localparam logic [2:0] O_CMP  = 3'd2;
  localparam logic [2:0] O_ST   = 3'd3;
  localparam logic [2:0] O_CAP  = 3'd4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] sys_w_addr = '0;
  logic [31:0] sys_w_line = '0;
  logic        sys_write = 1'b0;
  logic [31:0] sys_r_addr = '0;
  logic        sys_read = 1'b0;
  logic [31:0] sys_r_line;
  logic        sys_r_hit;
  logic        cap_in = 1'b0;
  logic        irq;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  sys_timer_periph #(
    .BASE          (B),
    .RESET_COMPARE (32'hFFFF_FFFF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sys_w_addr (sys_w_addr),
    .sys_w_line (sys_w_line),
    .sys_write  (sys_write),
    .sys_r_addr (sys_r_addr),
    .sys_read   (sys_read),
    .sys_r_line (sys_r_line),
    .sys_r_hit  (sys_r_hit),
    .cap_in     (cap_in),
    .irq        (irq)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  task automatic wr(input logic [2:0] ofs, input logic [31:0] d);
    sys_w_addr = B + {27'd0, ofs, 2'b00};
    sys_w_line = d;
    sys_write  = 1'b1;
    @(negedge clk);
    sys_write  = 1'b0;
  endtask

  task automatic rd(
    input  logic [31:0] a,
    output logic [31:0] d,
    output logic        h
  );
    sys_r_addr = a;
    sys_read   = 1'b1;
    @(negedge clk);
    sys_read   = 1'b0;
    d = sys_r_line;
    h = sys_r_hit;
  endtask

  task automatic rd_chk(
    input string       tag,
    input logic [2:0]  ofs,
    input logic [31:0] exp
  );
    logic [31:0] d;
    logic        h;
    rd(B + {27'd0, ofs, 2'b00}, d, h);
    chk({tag, ".hit"}, {31'd0, h}, 32'd1);
    chk(tag, d, exp);
  endtask

  initial begin
    logic [31:0] d;
    logic        h;

    repeat (3) @(negedge clk);
    chk("rst_line", sys_r_line, 32'd0);
    chk("rst_hit", {31'd0, sys_r_hit}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    rst = 1'b1;

    rd_chk("r_ctrl", O_CTRL, 32'd0);
    rd_chk("r_cnt", O_CNT, 32'd0);
    rd_chk("r_cmp", O_CMP, 32'hFFFF_FFFF);
    rd_chk("r_st", O_ST, 32'd0);
    rd_chk("r_cap", O_CAP, 32'd0);
    rd_chk("r_ofs5", 3'd5, 32'd0);
    rd(B + 32'h40, d, h);
    chk("miss_hit", {31'd0, h}, 32'd0);
    chk("miss_line", d, 32'd0);
    wr(3'd6, 32'hDEAD_BEEF);
    rd_chk("r_ofs6", 3'd6, 32'd0);

    // compare match with auto-reload
    wr(O_CMP, 32'd5);
    wr(O_CTRL, 32'h0000_0007);
    for (int i = 0; i < 7; i++) begin
      rd_chk($sformatf("ar_cnt%0d", i), O_CNT,
             (i < 6) ? i : 0);
      if (i == 5)
        chk("irq_lag", {31'd0, irq}, 32'd0);
    end
    chk("irq_set", {31'd0, irq}, 32'd1);
    rd_chk("match_st", O_ST, 32'd1);
    wr(O_ST, 32'd1);
    rd_chk("w1c_st", O_ST, 32'd0);
    chk("irq_clr", {31'd0, irq}, 32'd0);
    wr(O_CTRL, 32'd0);
    rd_chk("ctrl_rb", O_CTRL, 32'd0);

    // prescale 3: tick every 4 clocks
    wr(O_CNT, 32'd0);
    wr(O_CTRL, 32'h0000_0301);
    repeat (40) @(negedge clk);
    rd_chk("pre_cnt", O_CNT, 32'd10);
    wr(O_CTRL, 32'd0);

    // overflow wrap, irq disabled
    wr(O_CNT, 32'hFFFF_FFFE);
    wr(O_ST, 32'd7);
    wr(O_CTRL, 32'h0000_0001);
    @(negedge clk);
    wr(O_CTRL, 32'd0);
    rd_chk("ovf_cnt", O_CNT, 32'd0);
    rd_chk("ovf_st", O_ST, 32'd2);
    chk("ovf_irq", {31'd0, irq}, 32'd0);

    // COUNT write beats a coincident tick
    wr(O_CTRL, 32'h0000_0001);
    wr(O_CNT, 32'h0000_0100);
    rd_chk("wr_tick", O_CNT, 32'h0000_0100);
    wr(O_CTRL, 32'd0);
    rd_chk("hold_cnt", O_CNT, 32'h0000_0102);

    // match set beats same-cycle W1C
    wr(O_CMP, 32'h10);
    wr(O_CNT, 32'h0E);
    wr(O_ST, 32'd7);
    wr(O_CTRL, 32'h0000_0001);
    repeat (2) @(negedge clk);
    wr(O_ST, 32'd1);
    wr(O_CTRL, 32'd0);
    rd_chk("set_wins", O_ST, 32'd1);

    // reset while counting with irq pending
    wr(O_CMP, 32'd3);
    wr(O_CNT, 32'd0);
    wr(O_ST, 32'd7);
    wr(O_CTRL, 32'h0000_0007);
    repeat (8) @(negedge clk);
    chk("pre_rst_irq", {31'd0, irq}, 32'd1);
    sys_r_addr = B + 32'h8;
    sys_read   = 1'b1;
    rst        = 1'b0;
    @(negedge clk);
    sys_read   = 1'b0;
    chk("mid_rst_line", sys_r_line, 32'd0);
    chk("mid_rst_hit", {31'd0, sys_r_hit}, 32'd0);
    chk("mid_rst_irq", {31'd0, irq}, 32'd0);
    rst = 1'b1;
    rd_chk("mr_ctrl", O_CTRL, 32'd0);
    rd_chk("mr_cnt", O_CNT, 32'd0);
    rd_chk("mr_cmp", O_CMP, 32'hFFFF_FFFF);
    rd_chk("mr_st", O_ST, 32'd0);

    // capture input pulse with COUNT parked at 0x20
    wr(O_CNT, 32'h20);
    cap_in = 1'b1;
    repeat (2) @(negedge clk);
    cap_in = 1'b0;
    repeat (4) @(negedge clk);
`ifdef SYS_TIMER_CAPTURE_EN
    rd_chk("cap_val", O_CAP, 32'h20);
    rd_chk("cap_st", O_ST, 32'd4);
`else
    rd_chk("cap_val", O_CAP, 32'd0);
    rd_chk("cap_st", O_ST, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sys_timer_periph.md
Name: sys_timer_periph

Overview:
- Responder on the core's sys peripheral bus. The core is the initiator and drives the sys read/write address, line and strobe signals.
- Implements a memory-mapped 32-bit timer: prescaler, compare match with optional auto-reload, overflow flag and interrupt request.
- Instantiated in the processor assembly next to the RAM. It decodes its own address window and flags hits so the assembly can mux read data back into the core's sys read line.

Parameters:
- BASE, 32'h0000_1000: byte base address of the 32-byte register window; bits [4:0] must be 0.
- RESET_COMPARE, 32'hFFFF_FFFF: reset value of the COMPARE register.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-low reset (rst==0 resets on the clk edge).
- sys_w_addr  in  32  write byte address from core.
- sys_w_line  in  32  write data from core.
- sys_write  in  1  write strobe, single cycle per access.
- sys_r_addr  in  32  read byte address from core.
- sys_read  in  1  read strobe.
- sys_r_line  out  32  read data, registered.
- sys_r_hit  out  1  registered; high when sys_r_line carries this block's data.
- cap_in  in  1  capture input; used only with the optional feature.
- irq  out  1  registered interrupt request.

Behaviour:
- Address decode:
  - Hit when addr[31:5]==BASE[31:5]; register offset is addr[4:2]; addr[1:0] are ignored.
  - Offset 0 CTRL: bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN, [15:8] PRESCALE; other bits read 0.
  - Offset 1 COUNT (RW). Offset 2 COMPARE (RW).
  - Offset 3 STATUS: bit0 MATCH, bit1 OVF, bit2 CAP; write-1-to-clear.
  - Offset 4 CAPTURE (RO). Offsets 5-7 read 0; writes to them are ignored.
- Reset (rst==0): CTRL=0, COUNT=0, COMPARE=RESET_COMPARE, STATUS=0, CAPTURE=0, prescaler=0, sys_r_line=0, sys_r_hit=0, irq=0. Reset applied mid-count abandons all state immediately.
- Read:
  - sys_read && hit in cycle N → sys_r_line = register value sampled in cycle N, valid at cycle N+1, with sys_r_hit=1 in N+1.
  - Otherwise sys_r_line=0 and sys_r_hit=0 at N+1. Fixed 1-cycle latency, no wait states.
- Write: sys_write && hit in cycle N → register updated at the N+1 edge. Writes to read-only fields are ignored.
- Prescaler:
  - 8-bit pre_cnt counts only while EN=1.
  - When pre_cnt==PRESCALE: tick=1, pre_cnt←0; else pre_cnt←pre_cnt+1. PRESCALE=0 gives a tick every cycle.
  - Writing CTRL clears pre_cnt. EN=0 holds pre_cnt at 0.
- On tick:
  - If COUNT==COMPARE: MATCH←1, and COUNT←0 when AUTO_RELOAD=1, else COUNT←COUNT+1.
  - Else COUNT←COUNT+1.
  - 32'hFFFF_FFFF+1 wraps to 0 and sets OVF.
- Simultaneous events:
  - Software write to COUNT in the same cycle as a tick: the write wins and the tick is lost.
  - Hardware set of a STATUS bit in the same cycle as its W1C: set wins.
  - Read and write to the same register in one cycle: the read returns the pre-write value.
- irq is registered: irq ← IRQ_EN & (MATCH|OVF|CAP), i.e. one cycle after the flag.

Optional Feature:
- SYS_TIMER_CAPTURE_EN
- Defined:
  - cap_in passes through a 2-flop synchronizer.
  - A synchronized rising edge latches COUNT into CAPTURE and sets CAP.
  - The capture value is COUNT before any same-cycle tick or write.
- Undefined: cap_in is ignored; CAPTURE and CAP read 0 and the synchronizer is not built.

Decomposition:
- Package sys_timer_pkg:
  - Register offsets: OFS_CTRL=3'd0 … OFS_CAPTURE=3'd4.
  - CTRL and STATUS bit positions; PRESCALE field bounds.
- One sub-module, sys_prescaler (8-bit divider with en and clear, outputs tick).
- Register file, decode and read mux stay in the top.

Test Plan:
- Reset then read each offset 0-4 → CTRL=0, COUNT=0, COMPARE=0xFFFFFFFF, STATUS=0; each read shows sys_r_hit=1 one cycle after sys_read. Read at BASE+0x40 → sys_r_hit=0, sys_r_line=0.
- COMPARE=5, CTRL=0x7 (EN, AUTO_RELOAD, IRQ_EN, PRESCALE=0):
  - COUNT goes 0..5, then 0 on the tick after the match.
  - MATCH rises on the match tick; irq rises one cycle later.
  - Write STATUS=1 → MATCH and irq clear.
- CTRL=0x0301 (PRESCALE=3, EN): COUNT increments every 4 clk; 40 cycles from enable → COUNT=10.
- COUNT=0xFFFFFFFE, EN, no reload → wraps to 0 after 2 ticks, OVF=1, MATCH=0; with IRQ_EN=0, irq stays 0.
- Corner cases:
  - Write COUNT=0x100 in the same cycle as a tick → COUNT=0x100.
  - W1C of MATCH in the same cycle as a new match → MATCH stays 1.
  - rst=0 asserted while counting → all outputs 0 at the next edge.
- With SYS_TIMER_CAPTURE_EN: pulse cap_in while COUNT=0x20 → after the synchronizer delay CAPTURE reads a value in 0x20..0x22 per the delay, and CAP=1. Without the macro, CAPTURE reads 0.
